// File: rtl/sm3_axil_master.sv
// AXI4-Lite master that feeds message bytes to an SM3 slave, polls its status
// register and collects the 256-bit digest from eight data-register reads.
module sm3_axil_master #(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          POLL_GAP  = 4,
    parameter int          POLL_MAX  = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   in_data,
    input  logic         in_last,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [255:0] digest,
    output logic         digest_valid,
    input  logic         digest_ready,
    output logic         busy,
    output logic         err,
    output logic [31:0]  m_awaddr,
    output logic [2:0]   m_awprot,
    output logic         m_awvalid,
    input  logic         m_awready,
    output logic [31:0]  m_wdata,
    output logic [3:0]   m_wstrb,
    output logic         m_wvalid,
    input  logic         m_wready,
    input  logic         m_bvalid,
    output logic         m_bready,
    output logic [31:0]  m_araddr,
    output logic [2:0]   m_arprot,
    output logic         m_arvalid,
    input  logic         m_arready,
    input  logic [31:0]  m_rdata,
    input  logic         m_rvalid,
    output logic         m_rready
);
    localparam logic [3:0] IDLE    = 4'd0;
    localparam logic [3:0] WR      = 4'd1;
    localparam logic [3:0] WRESP   = 4'd2;
    localparam logic [3:0] POLL_AR = 4'd3;
    localparam logic [3:0] POLL_R  = 4'd4;
    localparam logic [3:0] GAP     = 4'd5;
    localparam logic [3:0] RD_AR   = 4'd6;
    localparam logic [3:0] RD_R    = 4'd7;
    localparam logic [3:0] OUT     = 4'd8;

    localparam logic [15:0] PMAX = 16'(POLL_MAX);
    localparam logic [7:0]  GAPN = 8'(POLL_GAP);

    logic [3:0]   state;
    logic [7:0]   byte_q;
    logic         last_q;
    logic         aw_done;
    logic         w_done;
    logic [15:0]  poll_cnt;
    logic [15:0]  poll_nxt;
    logic [7:0]   gap_cnt;
    logic [2:0]   word_cnt;
    logic [255:0] digest_q;
    logic         err_q;
    logic         aw_hs;
    logic         w_hs;

    assign in_ready     = (state == IDLE);
    assign busy         = (state != IDLE);
    assign digest_valid = (state == OUT);
    assign digest       = digest_q;
    assign err          = err_q;

    // Each write channel drops its valid on its own handshake; the other keeps waiting.
    assign m_awvalid = (state == WR) && !aw_done;
    assign m_wvalid  = (state == WR) && !w_done;
    assign m_awaddr  = (state == WR) ? BASE_ADDR : 32'd0;
    assign m_wdata   = (state == WR) ? {23'd0, last_q, byte_q} : 32'd0;
    assign m_wstrb   = 4'hF;
    assign m_awprot  = 3'b000;
    assign m_arprot  = 3'b000;
    assign m_bready  = (state == WRESP);
    assign m_arvalid = (state == POLL_AR) || (state == RD_AR);
    assign m_araddr  = (state == POLL_AR) ? BASE_ADDR + 32'd4 :
                       (state == RD_AR)   ? BASE_ADDR + 32'd8 : 32'd0;
    assign m_rready  = (state == POLL_R) || (state == RD_R);

    assign aw_hs    = m_awvalid && m_awready;
    assign w_hs     = m_wvalid && m_wready;
    assign poll_nxt = poll_cnt + 16'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            byte_q   <= 8'd0;
            last_q   <= 1'b0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            poll_cnt <= 16'd0;
            gap_cnt  <= 8'd0;
            word_cnt <= 3'd0;
            digest_q <= 256'd0;
            err_q    <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        byte_q  <= in_data;
                        last_q  <= in_last;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        state   <= WR;
                    end
                end
                WR: begin
                    if (aw_hs) aw_done <= 1'b1;
                    if (w_hs)  w_done  <= 1'b1;
                    if ((aw_done || aw_hs) && (w_done || w_hs)) state <= WRESP;
                end
                WRESP: begin
                    if (m_bvalid) begin
                        if (last_q) begin
                            poll_cnt <= 16'd0;
                            word_cnt <= 3'd0;
                            state    <= POLL_AR;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                POLL_AR: if (m_arready) state <= POLL_R;
                POLL_R: begin
                    if (m_rvalid) begin
                        if (m_rdata[0]) begin
                            word_cnt <= 3'd0;
                            state    <= RD_AR;
                        end else begin
                            poll_cnt <= poll_nxt;
                            gap_cnt  <= 8'd0;
                            if (poll_nxt >= PMAX) begin
                                err_q <= 1'b1;
                                state <= IDLE;
                            end else if (GAPN == 8'd0) begin
                                state <= POLL_AR;
                            end else begin
                                state <= GAP;
                            end
                        end
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt + 8'd1;
                    if (gap_cnt >= GAPN - 8'd1) state <= POLL_AR;
                end
                RD_AR: if (m_arready) state <= RD_R;
                RD_R: begin
                    if (m_rvalid) begin
                        // Word 0 lands in the top 32 bits.
                        for (int k = 0; k < 8; k++)
                            if (word_cnt == 3'(k)) digest_q[255-32*k -: 32] <= m_rdata;
                        if (word_cnt == 3'd7) state <= OUT;
                        else begin
                            word_cnt <= word_cnt + 3'd1;
                            state    <= RD_AR;
                        end
                    end
                end
                OUT: if (digest_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sm3_axil_master.sv
// Directed bench for sm3_axil_master: one instance with a configurable slave
// model, a second with POLL_MAX = 3 and a status register that never sets.
module tb_sm3_axil_master;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    localparam logic [255:0] EXP_ABC =
        256'h66c7f0f4_62eeedd9_d1f2d46b_dc10e4e2_4167c487_5cf2f7a2_297da02b_8f4ba8e0;

    // primary instance
    logic [7:0]   in_data = 8'd0;
    logic         in_last = 1'b0, in_valid = 1'b0, in_ready;
    logic [255:0] digest;
    logic         digest_valid, digest_ready = 1'b0, busy, err;
    logic [31:0]  m_awaddr, m_wdata, m_araddr;
    logic [31:0]  m_rdata;
    logic [2:0]   m_awprot, m_arprot;
    logic [3:0]   m_wstrb;
    logic         m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic         m_arvalid, m_arready, m_rvalid, m_rready;

    sm3_axil_master #(.BASE_ADDR(32'h0), .POLL_GAP(4), .POLL_MAX(1024)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
        .digest(digest), .digest_valid(digest_valid), .digest_ready(digest_ready),
        .busy(busy), .err(err),
        .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    // timeout instance
    logic [7:0]   in_data2 = 8'd0;
    logic         in_last2 = 1'b0, in_valid2 = 1'b0, in_ready2;
    logic [255:0] digest2;
    logic         digest_valid2, digest_ready2 = 1'b1, busy2, err2;
    logic [31:0]  m_awaddr2, m_wdata2, m_araddr2;
    logic [31:0]  m_rdata2 = 32'd0;
    logic [2:0]   m_awprot2, m_arprot2;
    logic [3:0]   m_wstrb2;
    logic         m_awvalid2, m_wvalid2, m_bready2, m_arvalid2, m_rready2;
    logic         m_awready2 = 1'b1, m_wready2 = 1'b1, m_arready2 = 1'b1;
    logic         m_bvalid2, m_rvalid2;

    sm3_axil_master #(.BASE_ADDR(32'h0), .POLL_GAP(0), .POLL_MAX(3)) dut2 (
        .clk(clk), .rst(rst),
        .in_data(in_data2), .in_last(in_last2), .in_valid(in_valid2), .in_ready(in_ready2),
        .digest(digest2), .digest_valid(digest_valid2), .digest_ready(digest_ready2),
        .busy(busy2), .err(err2),
        .m_awaddr(m_awaddr2), .m_awprot(m_awprot2), .m_awvalid(m_awvalid2), .m_awready(m_awready2),
        .m_wdata(m_wdata2), .m_wstrb(m_wstrb2), .m_wvalid(m_wvalid2), .m_wready(m_wready2),
        .m_bvalid(m_bvalid2), .m_bready(m_bready2),
        .m_araddr(m_araddr2), .m_arprot(m_arprot2), .m_arvalid(m_arvalid2), .m_arready(m_arready2),
        .m_rdata(m_rdata2), .m_rvalid(m_rvalid2), .m_rready(m_rready2)
    );

    // slave model for the primary instance
    int aw_wait = 0, w_wait = 0, st_zero = 0;
    int aw_age = 0, w_age = 0, poll_idx = 0, rd_idx = 0, cyc = 0;
    int aw_cnt = 0, w_cnt = 0, b_cnt = 0, err_cyc = 0;
    logic aw_seen = 1'b0, w_seen = 1'b0;
    logic [31:0] wlog[$];
    logic [31:0] ar_addr[$];
    int ar_cyc[$];
    logic [31:0] dig_w [8] = '{32'h66c7f0f4, 32'h62eeedd9, 32'hd1f2d46b, 32'hdc10e4e2,
                               32'h4167c487, 32'h5cf2f7a2, 32'h297da02b, 32'h8f4ba8e0};

    assign m_awready = m_awvalid && (aw_age >= aw_wait);
    assign m_wready  = m_wvalid && (w_age >= w_wait);
    assign m_arready = m_arvalid;

    always @(posedge clk) begin
        logic aw_now, w_now;
        cyc <= cyc + 1;
        err_cyc <= err_cyc + int'(err);
        if (rst) begin
            aw_age <= 0; w_age <= 0; aw_seen <= 1'b0; w_seen <= 1'b0;
            m_bvalid <= 1'b0; m_rvalid <= 1'b0; m_rdata <= 32'd0;
            poll_idx <= 0; rd_idx <= 0;
        end else begin
            aw_age <= (m_awvalid && !m_awready) ? aw_age + 1 : 0;
            w_age  <= (m_wvalid && !m_wready) ? w_age + 1 : 0;
            aw_now = aw_seen || (m_awvalid && m_awready);
            w_now  = w_seen || (m_wvalid && m_wready);
            if (m_awvalid && m_awready) aw_cnt <= aw_cnt + 1;
            if (m_wvalid && m_wready) begin
                w_cnt <= w_cnt + 1;
                wlog.push_back(m_wdata);
            end
            if (m_bvalid && m_bready) begin
                m_bvalid <= 1'b0;
                b_cnt <= b_cnt + 1;
            end
            if (aw_now && w_now && !m_bvalid) begin
                m_bvalid <= 1'b1; aw_seen <= 1'b0; w_seen <= 1'b0;
            end else begin
                aw_seen <= aw_now; w_seen <= w_now;
            end
            if (m_rvalid && m_rready) m_rvalid <= 1'b0;
            if (m_arvalid && m_arready) begin
                ar_addr.push_back(m_araddr);
                ar_cyc.push_back(cyc);
                m_rvalid <= 1'b1;
                if (m_araddr == 32'h4) begin
                    if (poll_idx < st_zero) begin
                        m_rdata <= 32'd0; poll_idx <= poll_idx + 1;
                    end else begin
                        m_rdata <= 32'd1; poll_idx <= 0; rd_idx <= 0;
                    end
                end else begin
                    m_rdata <= dig_w[rd_idx & 7];
                    rd_idx <= rd_idx + 1;
                end
            end
        end
    end

    // always-ready slave for the timeout instance; status reads 0
    int ar2_cnt = 0, err2_cyc = 0;
    logic dv2_seen = 1'b0;
    always @(posedge clk) begin
        ar2_cnt  <= ar2_cnt + int'(m_arvalid2);
        err2_cyc <= err2_cyc + int'(err2);
        if (digest_valid2) dv2_seen <= 1'b1;
        if (rst) begin
            m_bvalid2 <= 1'b0; m_rvalid2 <= 1'b0;
        end else begin
            if (m_bvalid2 && m_bready2) m_bvalid2 <= 1'b0;
            else if (m_awvalid2 && m_wvalid2) m_bvalid2 <= 1'b1;
            if (m_rvalid2 && m_rready2) m_rvalid2 <= 1'b0;
            else if (m_arvalid2) m_rvalid2 <= 1'b1;
        end
    end

    int errors = 0, checks = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input bit sel, input logic [7:0] b, input logic l);
        int t = 0;
        while (!(sel ? in_ready2 : in_ready) && t < 300) begin tick(); t++; end
        if (t >= 300) check("in_ready_timeout", 0, 1);
        if (sel) begin in_data2 = b; in_last2 = l; in_valid2 = 1'b1; end
        else     begin in_data  = b; in_last  = l; in_valid  = 1'b1; end
        tick();
        in_valid = 1'b0; in_valid2 = 1'b0;
    endtask

    initial begin
        int t, a0, w0, b0, ar0, wb;
        logic [7:0] msg [3];
        msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;

        // reset state
        tick(3);
        rst = 1'b0;
        tick();
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_dvalid", digest_valid, 0);
        check("rst_err", err, 0);
        check("rst_valids", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}, 0);
        check("rst_digest", digest, 0);
        check("rst_addr", {m_awaddr, m_araddr, m_wdata}, 0);

        // "abc" with five not-ready status reads
        st_zero = 5;
        wb = wlog.size();
        for (int i = 0; i < 3; i++) send_byte(0, msg[i], i == 2);
        t = 0;
        while (!digest_valid && t < 3000) begin tick(); t++; end
        if (t >= 3000) check("digest_timeout", 0, 1);
        check("digest", digest, EXP_ABC);
        check("wr_count", wlog.size() - wb, 3);
        check("wdata0", wlog[wb], 32'h061);
        check("wdata1", wlog[wb+1], 32'h062);
        check("wdata2", wlog[wb+2], 32'h163);
        check("ar_count", ar_addr.size(), 14);
        for (int i = 0; i < 14 && i < ar_addr.size(); i++)
            check($sformatf("ar_addr%0d", i), ar_addr[i], (i < 6) ? 32'h4 : 32'h8);
        for (int i = 1; i < 6 && i < ar_cyc.size(); i++)
            check($sformatf("poll_spacing%0d", i), (ar_cyc[i] - ar_cyc[i-1]) >= 5, 1);
        for (int i = 0; i < 10; i++) begin
            check("out_hold", {digest == EXP_ABC, digest_valid, in_ready}, 3'b110);
            tick();
        end
        digest_ready = 1'b1;
        tick();
        digest_ready = 1'b0;
        check("out_done", {in_ready, busy, digest_valid}, 3'b100);
        check("b_count", b_cnt, 3);
        check("no_err", err_cyc, 0);

        // W accepted three cycles before AW
        st_zero = 0; aw_wait = 3;
        a0 = aw_cnt; w0 = w_cnt; b0 = b_cnt; ar0 = ar_addr.size();
        send_byte(0, 8'h55, 0);
        check("skew_c0", {m_awvalid, m_wvalid, m_awready, m_wready}, 4'b1101);
        tick();
        check("skew_c1", {m_awvalid, m_wvalid}, 2'b10);
        tick();
        check("skew_c2", {m_awvalid, m_wvalid}, 2'b10);
        tick();
        check("skew_c3", {m_awvalid, m_awready, m_wvalid}, 3'b110);
        tick();
        check("skew_c4", {m_awvalid, m_wvalid, m_bvalid, m_bready}, 4'b0011);
        tick();
        check("skew_idle", in_ready, 1);
        tick(3);
        aw_wait = 0;
        check("skew_aw", aw_cnt - a0, 1);
        check("skew_w", w_cnt - w0, 1);
        check("skew_b", b_cnt - b0, 1);
        check("skew_wdata", wlog[wlog.size()-1], 32'h055);
        check("skew_no_ar", ar_addr.size(), ar0);

        // reset during the digest read phase
        send_byte(0, 8'h61, 1);
        t = 0;
        while (!(rd_idx >= 3 && m_rready) && t < 500) begin tick(); t++; end
        if (t >= 500) check("rd_r_timeout", 0, 1);
        rst = 1'b1;
        tick();
        check("abort_valids", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}, 0);
        check("abort_status", {digest_valid, busy, err}, 0);
        check("abort_digest", digest, 0);
        rst = 1'b0;
        ar0 = ar_addr.size();
        tick();
        check("abort_in_ready", in_ready, 1);
        tick(20);
        check("abort_quiet", {ar_addr.size() == ar0, digest_valid, busy}, 3'b100);

        // status never sets on the POLL_MAX = 3 instance
        send_byte(1, 8'h61, 1);
        t = 0;
        while (!err2 && t < 500) begin tick(); t++; end
        if (t >= 500) check("err_timeout", 0, 1);
        check("to_idle", {in_ready2, busy2}, 2'b10);
        tick();
        check("to_err_pulse", err2, 0);
        tick(20);
        check("to_polls", ar2_cnt, 3);
        check("to_err_cycles", err2_cyc, 1);
        check("to_no_digest", dv2_seen, 0);
        check("to_ready", in_ready2, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
